// File: rtl/rtc_bus_if.sv
// Multiplexed 8-bit address/data bus between the RTC reader (master) and the RTC chip (slave).
interface rtc_bus_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;

  modport master (input ad_in, output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d);
  modport slave  (output ad_in, input ad_out, ad_oe, cs_n, rd_n, wr_n, a_d);
endinterface

// File: rtl/rtc_bus_reader.sv
// Periodically bursts ten RTC registers into a shadow set, then publishes them atomically as BCD digits.
// state     | meaning
// S_IDLE    | bus parked, waiting for refresh wrap or refresh_req
// S_ADDR    | drive register address, cs_n/wr_n low
// S_ADDR_REL| strobes released, address still driven
// S_DATA    | bus released, cs_n/rd_n low, byte sampled on last cycle
// S_RECOVER | strobes high before next register or publish
// S_PUBLISH | shadow copied to outputs, update_tick high
module rtc_bus_reader #(
  parameter int T_PHASE        = 10,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       refresh_req,
  input  logic       pause,
  rtc_bus_if.master  bus,
  output logic [3:0] digit0_HH,
  output logic [3:0] digit1_HH,
  output logic [3:0] digit0_MM,
  output logic [3:0] digit1_MM,
  output logic [3:0] digit0_SS,
  output logic [3:0] digit1_SS,
  output logic [3:0] digit0_DAY,
  output logic [3:0] digit1_DAY,
  output logic [3:0] digit0_MES,
  output logic [3:0] digit1_MES,
  output logic [3:0] digit0_YEAR,
  output logic [3:0] digit1_YEAR,
  output logic [3:0] digit0_HH_T,
  output logic [3:0] digit1_HH_T,
  output logic [3:0] digit0_MM_T,
  output logic [3:0] digit1_MM_T,
  output logic [3:0] digit0_SS_T,
  output logic [3:0] digit1_SS_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana,
  output logic       busy,
  output logic       update_tick
);

  localparam int PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(T_PHASE - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_REL, S_DATA, S_RECOVER, S_PUBLISH
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   phase_cnt;
  logic [RW-1:0]   ref_cnt;
  logic [3:0]      reg_idx;
  logic [7:0]      addr;
  logic [9:0][7:0] shadow;
  logic [9:0][7:0] pub;
  logic            phase_done;
  logic            wrap;
  logic            pub_load;

  assign phase_done = (phase_cnt == '0);
  assign wrap       = (ref_cnt == REF_LAST);
  assign pub_load   = (state == S_RECOVER) && phase_done && (reg_idx == 4'd9);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      ref_cnt   <= '0;
      reg_idx   <= '0;
    end else begin
      state   <= state_nx;
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      // every state change reloads the phase timer, so each state lasts T_PHASE cycles
      if (state_nx != state)
        phase_cnt <= PHASE_LAST;
      else if (!phase_done)
        phase_cnt <= phase_cnt - 1'b1;
      if (state == S_IDLE)
        reg_idx <= '0;
      else if ((state == S_RECOVER) && phase_done)
        reg_idx <= reg_idx + 4'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (!pause && (wrap || refresh_req)) state_nx = S_ADDR;
      S_ADDR:     if (phase_done) state_nx = S_ADDR_REL;
      S_ADDR_REL: if (phase_done) state_nx = S_DATA;
      S_DATA:     if (phase_done) state_nx = S_RECOVER;
      S_RECOVER:  if (phase_done) state_nx = (reg_idx == 4'd9) ? S_PUBLISH : S_ADDR;
      S_PUBLISH:  state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    case (reg_idx)
      4'd0:    addr = 8'h21;
      4'd1:    addr = 8'h22;
      4'd2:    addr = 8'h23;
      4'd3:    addr = 8'h24;
      4'd4:    addr = 8'h25;
      4'd5:    addr = 8'h26;
      4'd6:    addr = 8'h27;
      4'd7:    addr = 8'h41;
      4'd8:    addr = 8'h42;
      4'd9:    addr = 8'h43;
      default: addr = 8'h21;
    endcase
  end

  always_comb begin
    bus.cs_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.a_d    = 1'b1;
    bus.ad_oe  = 1'b0;
    bus.ad_out = '0;
    case (state)
      S_ADDR: begin
        bus.cs_n   = 1'b0;
        bus.wr_n   = 1'b0;
        bus.a_d    = 1'b0;
        bus.ad_oe  = 1'b1;
        bus.ad_out = addr;
      end
      S_ADDR_REL: begin
        bus.a_d    = 1'b0;
        bus.ad_oe  = 1'b1;
        bus.ad_out = addr;
      end
      S_DATA: begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if ((state == S_DATA) && phase_done)
      shadow[reg_idx] <= bus.ad_in;
  end

  // outputs load on the edge into PUBLISH so they change in the update_tick cycle
  always_ff @(posedge clock) begin
    if (!reset)
      pub <= '0;
    else if (pub_load)
      pub <= shadow;
  end

  assign busy        = (state != S_IDLE);
  assign update_tick = (state == S_PUBLISH);

  assign digit0_SS   = pub[0][3:0];
  assign digit1_SS   = {1'b0, pub[0][6:4]};
  assign digit0_MM   = pub[1][3:0];
  assign digit1_MM   = {1'b0, pub[1][6:4]};
  assign digit0_HH   = pub[2][3:0];
  assign digit1_HH   = {2'b00, pub[2][5:4]};
  assign AM_PM       = pub[2][7];
  assign digit0_DAY  = pub[3][3:0];
  assign digit1_DAY  = {1'b0, pub[3][6:4]};
  assign digit0_MES  = pub[4][3:0];
  assign digit1_MES  = {1'b0, pub[4][6:4]};
  assign digit0_YEAR = pub[5][3:0];
  assign digit1_YEAR = {1'b0, pub[5][6:4]};
  assign dia_semana  = pub[6][2:0];
  assign digit0_SS_T = pub[7][3:0];
  assign digit1_SS_T = {1'b0, pub[7][6:4]};
  assign digit0_MM_T = pub[8][3:0];
  assign digit1_MM_T = {1'b0, pub[8][6:4]};
  assign digit0_HH_T = pub[9][3:0];
  assign digit1_HH_T = {2'b00, pub[9][5:4]};

  // bits the screen never consumes (HH bit 6, weekday high bits, HH_T bits 7:6)
  logic unused_bits;
  assign unused_bits = ^{pub[2][6], pub[6][7:3], pub[9][7:6]};

endmodule
